// File: rtl/vfifo_arb_pkg.sv
// Shared types and helpers for the virtual-FIFO memory-port arbiter.
package vfifo_arb_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_ADDR = 1'b1
    } rd_state_t;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam int unsigned AXI_ID_W       = 4;

    function automatic logic [2:0] axi_size(input int unsigned bytes);
        return 3'($clog2(bytes));
    endfunction

endpackage

// File: rtl/vfifo_mem_arbiter_if.sv
// Requester-side and memory-side AXI4 signals of the arbiter in one bundle.
interface vfifo_mem_arbiter_if #(
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned TDATA_BYTES = 8,
    parameter int unsigned ADDR_WIDTH  = 12
);
    import vfifo_arb_pkg::*;

    localparam int unsigned PORT_BITS = $clog2(NUM_PORTS);
    localparam int unsigned DATA_W    = 8 * TDATA_BYTES;
    localparam int unsigned MEM_AW    = ADDR_WIDTH + PORT_BITS;

    logic [NUM_PORTS-1:0]                  s_awvalid, s_awready;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  s_awaddr;
    logic [NUM_PORTS-1:0][7:0]             s_awlen;
    logic [NUM_PORTS-1:0]                  s_wvalid, s_wready, s_wlast;
    logic [NUM_PORTS-1:0][DATA_W-1:0]      s_wdata;
    logic [NUM_PORTS-1:0][TDATA_BYTES-1:0] s_wstrb;
    logic [NUM_PORTS-1:0]                  s_bvalid, s_bready;
    logic [NUM_PORTS-1:0][1:0]             s_bresp;
    logic [NUM_PORTS-1:0]                  s_arvalid, s_arready;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  s_araddr;
    logic [NUM_PORTS-1:0][7:0]             s_arlen;
    logic [NUM_PORTS-1:0]                  s_rvalid, s_rready;
    logic [DATA_W-1:0]                     s_rdata;
    logic [1:0]                            s_rresp;
    logic                                  s_rlast;

    logic                   mem_awvalid, mem_awready;
    logic [MEM_AW-1:0]      mem_awaddr;
    logic [7:0]             mem_awlen;
    logic [2:0]             mem_awsize;
    logic [1:0]             mem_awburst;
    logic [AXI_ID_W-1:0]    mem_awid;
    logic                   mem_wvalid, mem_wready, mem_wlast;
    logic [DATA_W-1:0]      mem_wdata;
    logic [TDATA_BYTES-1:0] mem_wstrb;
    logic                   mem_bvalid, mem_bready;
    logic [AXI_ID_W-1:0]    mem_bid;
    logic [1:0]             mem_bresp;
    logic                   mem_arvalid, mem_arready;
    logic [MEM_AW-1:0]      mem_araddr;
    logic [7:0]             mem_arlen;
    logic [2:0]             mem_arsize;
    logic [1:0]             mem_arburst;
    logic [AXI_ID_W-1:0]    mem_arid;
    logic                   mem_rvalid, mem_rready, mem_rlast;
    logic [DATA_W-1:0]      mem_rdata;
    logic [AXI_ID_W-1:0]    mem_rid;
    logic [1:0]             mem_rresp;

    // Arbiter view: slave to the requesters, master to the memory.
    modport slave (
        input  s_awvalid, s_awaddr, s_awlen, s_wvalid, s_wdata, s_wstrb, s_wlast,
               s_bready, s_arvalid, s_araddr, s_arlen, s_rready,
               mem_awready, mem_wready, mem_bvalid, mem_bid, mem_bresp,
               mem_arready, mem_rvalid, mem_rdata, mem_rid, mem_rresp, mem_rlast,
        output s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid,
               s_rdata, s_rresp, s_rlast,
               mem_awvalid, mem_awaddr, mem_awlen, mem_awsize, mem_awburst, mem_awid,
               mem_wvalid, mem_wdata, mem_wstrb, mem_wlast, mem_bready,
               mem_arvalid, mem_araddr, mem_arlen, mem_arsize, mem_arburst, mem_arid,
               mem_rready
    );

    // Environment view: requesters plus memory controller.
    modport master (
        output s_awvalid, s_awaddr, s_awlen, s_wvalid, s_wdata, s_wstrb, s_wlast,
               s_bready, s_arvalid, s_araddr, s_arlen, s_rready,
               mem_awready, mem_wready, mem_bvalid, mem_bid, mem_bresp,
               mem_arready, mem_rvalid, mem_rdata, mem_rid, mem_rresp, mem_rlast,
        input  s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid,
               s_rdata, s_rresp, s_rlast,
               mem_awvalid, mem_awaddr, mem_awlen, mem_awsize, mem_awburst, mem_awid,
               mem_wvalid, mem_wdata, mem_wstrb, mem_wlast, mem_bready,
               mem_arvalid, mem_araddr, mem_arlen, mem_arsize, mem_arburst, mem_arid,
               mem_rready
    );

endinterface

// File: rtl/vfifo_mem_arbiter_rr_arbiter.sv
// Combinational round-robin pick: lowest index at or after prio (wrapping) wins.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] prio,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_valid
);
    localparam int unsigned PW = $clog2(N);

    int unsigned   idx;
    logic [PW-1:0] idx_t;

    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        idx_t       = '0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = 32'(prio) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_t = PW'(idx);
            if (!grant_valid && req[idx_t]) begin
                grant_idx   = idx_t;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vfifo_mem_arbiter.sv
// Shares one AXI4 memory port among NUM_PORTS virtual FIFOs; each port owns
// the address region selected by its index in the top address bits.
module vfifo_mem_arbiter
    import vfifo_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned TDATA_BYTES = 8,
    parameter int unsigned ADDR_WIDTH  = 12
) (
    input  logic                aclk,
    input  logic                aresetn,
    vfifo_mem_arbiter_if.slave  bus
);
    localparam int unsigned PORT_BITS = $clog2(NUM_PORTS);
    localparam int unsigned MEM_AW    = ADDR_WIDTH + PORT_BITS;
    localparam int unsigned ID_CMP_W  = AXI_ID_W + 1;
    localparam logic [ID_CMP_W-1:0] NUM_IDS = ID_CMP_W'(NUM_PORTS);

    function automatic logic [PORT_BITS-1:0] next_port(input logic [PORT_BITS-1:0] p);
        return (p == PORT_BITS'(NUM_PORTS - 1)) ? '0 : p + PORT_BITS'(1);
    endfunction

    wr_state_t             wr_state, wr_state_n;
    rd_state_t             rd_state, rd_state_n;
    logic [PORT_BITS-1:0]  wr_grant, wr_grant_n, wr_prio, wr_prio_n;
    logic [PORT_BITS-1:0]  rd_grant, rd_grant_n, rd_prio, rd_prio_n;
    logic [MEM_AW-1:0]     aw_addr_q, aw_addr_n, ar_addr_q, ar_addr_n;
    logic [7:0]            aw_len_q, aw_len_n, ar_len_q, ar_len_n;
    logic [PORT_BITS-1:0]  aw_idx, ar_idx;
    logic                  aw_any, ar_any;

    rr_arbiter #(.N(NUM_PORTS)) u_aw_arb (
        .req(bus.s_awvalid), .prio(wr_prio), .grant_idx(aw_idx), .grant_valid(aw_any)
    );

    rr_arbiter #(.N(NUM_PORTS)) u_ar_arb (
        .req(bus.s_arvalid), .prio(rd_prio), .grant_idx(ar_idx), .grant_valid(ar_any)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state  <= W_IDLE;
            wr_grant  <= '0;
            wr_prio   <= '0;
            aw_addr_q <= '0;
            aw_len_q  <= '0;
            rd_state  <= R_IDLE;
            rd_grant  <= '0;
            rd_prio   <= '0;
            ar_addr_q <= '0;
            ar_len_q  <= '0;
        end else begin
            wr_state  <= wr_state_n;
            wr_grant  <= wr_grant_n;
            wr_prio   <= wr_prio_n;
            aw_addr_q <= aw_addr_n;
            aw_len_q  <= aw_len_n;
            rd_state  <= rd_state_n;
            rd_grant  <= rd_grant_n;
            rd_prio   <= rd_prio_n;
            ar_addr_q <= ar_addr_n;
            ar_len_q  <= ar_len_n;
        end
    end

    // Write side: the W channel stays locked to the granted port until wlast.
    always_comb begin
        wr_state_n      = wr_state;
        wr_grant_n      = wr_grant;
        wr_prio_n       = wr_prio;
        aw_addr_n       = aw_addr_q;
        aw_len_n        = aw_len_q;
        bus.mem_awvalid = 1'b0;
        bus.s_awready   = '0;
        bus.s_wready    = '0;
        bus.mem_wvalid  = 1'b0;
        bus.mem_wdata   = '0;
        bus.mem_wstrb   = '0;
        bus.mem_wlast   = 1'b0;
        case (wr_state)
            W_IDLE: begin
                if (aw_any) begin
                    wr_grant_n = aw_idx;
                    aw_addr_n  = {aw_idx, bus.s_awaddr[aw_idx]};
                    aw_len_n   = bus.s_awlen[aw_idx];
                    wr_state_n = W_ADDR;
                end
            end
            W_ADDR: begin
                bus.mem_awvalid = 1'b1;
                if (bus.mem_awready) begin
                    bus.s_awready[wr_grant] = 1'b1;
                    wr_state_n              = W_DATA;
                end
            end
            W_DATA: begin
                bus.mem_wvalid         = bus.s_wvalid[wr_grant];
                bus.mem_wdata          = bus.s_wdata[wr_grant];
                bus.mem_wstrb          = bus.s_wstrb[wr_grant];
                bus.mem_wlast          = bus.s_wlast[wr_grant];
                bus.s_wready[wr_grant] = bus.mem_wready;
                if (bus.s_wvalid[wr_grant] && bus.mem_wready && bus.s_wlast[wr_grant]) begin
                    wr_prio_n  = next_port(wr_grant);
                    wr_state_n = W_IDLE;
                end
            end
            default: wr_state_n = W_IDLE;
        endcase
    end

    // Read side: only the AR channel is arbitrated; R returns by ID.
    always_comb begin
        rd_state_n      = rd_state;
        rd_grant_n      = rd_grant;
        rd_prio_n       = rd_prio;
        ar_addr_n       = ar_addr_q;
        ar_len_n        = ar_len_q;
        bus.mem_arvalid = 1'b0;
        bus.s_arready   = '0;
        case (rd_state)
            R_IDLE: begin
                if (ar_any) begin
                    rd_grant_n = ar_idx;
                    ar_addr_n  = {ar_idx, bus.s_araddr[ar_idx]};
                    ar_len_n   = bus.s_arlen[ar_idx];
                    rd_state_n = R_ADDR;
                end
            end
            R_ADDR: begin
                bus.mem_arvalid = 1'b1;
                if (bus.mem_arready) begin
                    bus.s_arready[rd_grant] = 1'b1;
                    rd_prio_n               = next_port(rd_grant);
                    rd_state_n              = R_IDLE;
                end
            end
            default: rd_state_n = R_IDLE;
        endcase
    end

    assign bus.mem_awaddr  = aw_addr_q;
    assign bus.mem_awlen   = aw_len_q;
    assign bus.mem_awsize  = axi_size(TDATA_BYTES);
    assign bus.mem_awburst = AXI_BURST_INCR;
    assign bus.mem_awid    = AXI_ID_W'(wr_grant);
    assign bus.mem_araddr  = ar_addr_q;
    assign bus.mem_arlen   = ar_len_q;
    assign bus.mem_arsize  = axi_size(TDATA_BYTES);
    assign bus.mem_arburst = AXI_BURST_INCR;
    assign bus.mem_arid    = AXI_ID_W'(rd_grant);

    // Response routing; an out-of-range ID is swallowed so the memory never hangs.
    always_comb begin
        bus.s_bvalid   = '0;
        bus.mem_bready = 1'b1;
        if ({1'b0, bus.mem_bid} < NUM_IDS) begin
            bus.s_bvalid[bus.mem_bid[PORT_BITS-1:0]] = bus.mem_bvalid;
            bus.mem_bready = bus.s_bready[bus.mem_bid[PORT_BITS-1:0]];
        end
    end

    always_comb begin
        bus.s_rvalid   = '0;
        bus.mem_rready = 1'b1;
        if ({1'b0, bus.mem_rid} < NUM_IDS) begin
            bus.s_rvalid[bus.mem_rid[PORT_BITS-1:0]] = bus.mem_rvalid;
            bus.mem_rready = bus.s_rready[bus.mem_rid[PORT_BITS-1:0]];
        end
    end

    assign bus.s_bresp = {NUM_PORTS{bus.mem_bresp}};
    assign bus.s_rdata = bus.mem_rdata;
    assign bus.s_rresp = bus.mem_rresp;
    assign bus.s_rlast = bus.mem_rlast;

endmodule

// File: tb/tb_vfifo_mem_arbiter.sv
// Directed bench for vfifo_mem_arbiter with two requesters, 8-byte data, 12-bit regions.
module tb_vfifo_mem_arbiter;
    localparam int unsigned NP = 2;
    localparam int unsigned TB = 8;
    localparam int unsigned AW = 12;

    logic        aclk    = 1'b0;
    logic        aresetn = 1'b0;
    int unsigned vecs    = 0;
    int unsigned errs    = 0;

    vfifo_mem_arbiter_if #(.NUM_PORTS(NP), .TDATA_BYTES(TB), .ADDR_WIDTH(AW)) bus ();

    vfifo_mem_arbiter #(.NUM_PORTS(NP), .TDATA_BYTES(TB), .ADDR_WIDTH(AW)) dut (
        .aclk(aclk), .aresetn(aresetn), .bus(bus)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Single-beat write; caller holds s_awvalid[p] in W_IDLE, awready/wready high.
    task automatic wr_single(input logic p, input logic [11:0] addr);
        tick();
        chk("wr_awvalid", 64'(bus.mem_awvalid), 64'(1));
        chk("wr_awid", 64'(bus.mem_awid), 64'(p));
        chk("wr_awaddr", 64'(bus.mem_awaddr), (64'(p) << 12) | 64'(addr));
        chk("wr_awready", 64'(bus.s_awready), 64'(1) << p);
        bus.s_awvalid[p] = 1'b0;
        tick();
        bus.s_wvalid[p] = 1'b1;
        bus.s_wlast[p]  = 1'b1;
        #1;
        chk("wr_wready", 64'(bus.s_wready), 64'(1) << p);
        chk("wr_wlast", 64'(bus.mem_wlast), 64'(1));
        tick();
        bus.s_wvalid[p] = 1'b0;
        bus.s_wlast[p]  = 1'b0;
    endtask

    initial begin
        bus.s_awvalid = '0; bus.s_awaddr = '0; bus.s_awlen = '0;
        bus.s_wvalid = '0; bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_wlast = '0;
        bus.s_bready = '0; bus.s_arvalid = '0; bus.s_araddr = '0; bus.s_arlen = '0;
        bus.s_rready = '0;
        bus.mem_awready = 1'b0; bus.mem_wready = 1'b0; bus.mem_bvalid = 1'b0;
        bus.mem_bid = '0; bus.mem_bresp = '0; bus.mem_arready = 1'b0;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.mem_rid = '0;
        bus.mem_rresp = '0; bus.mem_rlast = 1'b0;

        tick();
        tick();
        chk("rst_awvalid", 64'(bus.mem_awvalid), 64'(0));
        chk("rst_arvalid", 64'(bus.mem_arvalid), 64'(0));
        chk("rst_wvalid", 64'(bus.mem_wvalid), 64'(0));
        chk("rst_wlast", 64'(bus.mem_wlast), 64'(0));
        chk("rst_awaddr", 64'(bus.mem_awaddr), 64'(0));
        chk("rst_s_ready", 64'({bus.s_awready, bus.s_arready, bus.s_wready}), 64'(0));
        aresetn = 1'b1;
        tick();

        // Port 1 alone: 4-beat burst into region 1
        bus.s_awvalid[1] = 1'b1; bus.s_awaddr[1] = 12'h040; bus.s_awlen[1] = 8'd3;
        #1;
        chk("t1_aw_latency", 64'(bus.mem_awvalid), 64'(0));
        tick();
        chk("t1_awvalid", 64'(bus.mem_awvalid), 64'(1));
        chk("t1_awaddr", 64'(bus.mem_awaddr), 64'h1040);
        chk("t1_awid", 64'(bus.mem_awid), 64'(1));
        chk("t1_awlen", 64'(bus.mem_awlen), 64'(3));
        chk("t1_awsize", 64'(bus.mem_awsize), 64'(3));
        chk("t1_awburst", 64'(bus.mem_awburst), 64'(1));
        chk("t1_awready_wait", 64'(bus.s_awready), 64'(0));
        bus.mem_awready = 1'b1;
        #1;
        chk("t1_awready", 64'(bus.s_awready), 64'b10);
        tick();
        bus.s_awvalid[1] = 1'b0; bus.mem_awready = 1'b0;
        bus.mem_wready = 1'b1; bus.s_wvalid[1] = 1'b1; bus.s_wstrb[1] = 8'hFF;
        for (int b = 0; b < 4; b++) begin
            bus.s_wdata[1] = 64'hCAFE_0000_0000_0000 | 64'(b);
            bus.s_wlast[1] = (b == 3);
            #1;
            chk("t1_wvalid", 64'(bus.mem_wvalid), 64'(1));
            chk("t1_wdata", 64'(bus.mem_wdata), 64'hCAFE_0000_0000_0000 | 64'(b));
            chk("t1_wlast", 64'(bus.mem_wlast), 64'(b == 3));
            chk("t1_wready", 64'(bus.s_wready), 64'b10);
            tick();
        end
        bus.s_wvalid[1] = 1'b0; bus.s_wlast[1] = 1'b0;
        #1;
        chk("t1_idle_wvalid", 64'(bus.mem_wvalid), 64'(0));

        // Simultaneous requests: prio 0 gives 0,1; after a lone port-0 burst prio 1 gives 1,0
        bus.mem_awready = 1'b1; bus.mem_wready = 1'b1;
        bus.s_awaddr[0] = 12'h100; bus.s_awaddr[1] = 12'h200; bus.s_awlen = '0;
        bus.s_awvalid = 2'b11;
        wr_single(1'b0, 12'h100);
        wr_single(1'b1, 12'h200);
        bus.s_awvalid[0] = 1'b1;
        wr_single(1'b0, 12'h100);
        bus.s_awvalid = 2'b11;
        wr_single(1'b1, 12'h200);
        wr_single(1'b0, 12'h100);

        // Port 0 holds the W channel through a 5-cycle wready stall
        bus.s_awvalid[0] = 1'b1; bus.s_awaddr[0] = 12'h300;
        tick();
        bus.s_awvalid[0] = 1'b0;
        tick();
        bus.mem_wready = 1'b0; bus.s_wvalid[0] = 1'b1; bus.s_wlast[0] = 1'b1;
        bus.s_awvalid[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t3_stall_awvalid", 64'(bus.mem_awvalid), 64'(0));
            chk("t3_stall_wready", 64'(bus.s_wready), 64'(0));
            tick();
        end
        bus.mem_wready = 1'b1;
        #1;
        chk("t3_wready", 64'(bus.s_wready), 64'b01);
        chk("t3_wvalid", 64'(bus.mem_wvalid), 64'(1));
        tick();
        bus.s_wvalid[0] = 1'b0; bus.s_wlast[0] = 1'b0;
        #1;
        chk("t3_idle_awvalid", 64'(bus.mem_awvalid), 64'(0));
        wr_single(1'b1, 12'h200);

        // Reads from both ports, then interleaved R routing by ID
        bus.mem_arready = 1'b1;
        bus.s_araddr[0] = 12'h010; bus.s_araddr[1] = 12'h020;
        bus.s_arlen[0] = 8'd1; bus.s_arlen[1] = 8'd2;
        bus.s_arvalid = 2'b11;
        #1;
        chk("t4_ar_latency", 64'(bus.mem_arvalid), 64'(0));
        tick();
        chk("t4_arvalid0", 64'(bus.mem_arvalid), 64'(1));
        chk("t4_arid0", 64'(bus.mem_arid), 64'(0));
        chk("t4_araddr0", 64'(bus.mem_araddr), 64'h0010);
        chk("t4_arlen0", 64'(bus.mem_arlen), 64'(1));
        chk("t4_arready0", 64'(bus.s_arready), 64'b01);
        bus.s_arvalid[0] = 1'b0;
        tick();
        chk("t4_ar_idle", 64'(bus.mem_arvalid), 64'(0));
        tick();
        chk("t4_arid1", 64'(bus.mem_arid), 64'(1));
        chk("t4_araddr1", 64'(bus.mem_araddr), 64'h1020);
        chk("t4_arlen1", 64'(bus.mem_arlen), 64'(2));
        chk("t4_arready1", 64'(bus.s_arready), 64'b10);
        bus.s_arvalid[1] = 1'b0;
        tick();
        bus.mem_rvalid = 1'b1; bus.mem_rid = 4'd1; bus.mem_rdata = 64'h1111;
        bus.mem_rlast = 1'b0; bus.s_rready = 2'b11;
        #1;
        chk("t4_rvalid_id1", 64'(bus.s_rvalid), 64'b10);
        chk("t4_rdata_id1", 64'(bus.s_rdata), 64'h1111);
        chk("t4_rready_id1", 64'(bus.mem_rready), 64'(1));
        bus.s_rready[1] = 1'b0;
        #1;
        chk("t4_rready_stall", 64'(bus.mem_rready), 64'(0));
        chk("t4_rvalid_stall", 64'(bus.s_rvalid), 64'b10);
        tick();
        bus.mem_rid = 4'd0; bus.mem_rdata = 64'h2222; bus.mem_rlast = 1'b1;
        bus.s_rready = 2'b01;
        #1;
        chk("t4_rvalid_id0", 64'(bus.s_rvalid), 64'b01);
        chk("t4_rdata_id0", 64'(bus.s_rdata), 64'h2222);
        chk("t4_rlast_id0", 64'(bus.s_rlast), 64'(1));
        chk("t4_rready_id0", 64'(bus.mem_rready), 64'(1));
        bus.mem_rid = 4'd5;
        #1;
        chk("t4_rvalid_badid", 64'(bus.s_rvalid), 64'(0));
        chk("t4_rready_badid", 64'(bus.mem_rready), 64'(1));
        bus.mem_rvalid = 1'b0;
        tick();

        // B routing, including an out-of-range ID
        bus.mem_bvalid = 1'b1; bus.mem_bid = 4'd3; bus.s_bready = '0; bus.mem_bresp = 2'b10;
        #1;
        chk("t5_bready_badid", 64'(bus.mem_bready), 64'(1));
        chk("t5_bvalid_badid", 64'(bus.s_bvalid), 64'(0));
        bus.mem_bid = 4'd1; bus.s_bready = 2'b10;
        #1;
        chk("t5_bvalid_id1", 64'(bus.s_bvalid), 64'b10);
        chk("t5_bready_id1", 64'(bus.mem_bready), 64'(1));
        chk("t5_bresp_id1", 64'(bus.s_bresp[1]), 64'b10);
        bus.s_bready = 2'b01;
        #1;
        chk("t5_bready_stall", 64'(bus.mem_bready), 64'(0));
        bus.mem_bvalid = 1'b0;
        tick();

        // Move both pointers to 1, then reset mid-burst
        bus.s_awvalid[0] = 1'b1;
        wr_single(1'b0, 12'h300);
        bus.s_arvalid[0] = 1'b1;
        tick();
        bus.s_arvalid[0] = 1'b0;
        tick();
        bus.s_awvalid[1] = 1'b1; bus.s_awlen[1] = 8'd3;
        tick();
        bus.s_awvalid[1] = 1'b0;
        tick();
        bus.s_wvalid[1] = 1'b1; bus.s_wlast[1] = 1'b0;
        bus.mem_arready = 1'b0; bus.s_arvalid[1] = 1'b1;
        tick();
        chk("t6_pre_wvalid", 64'(bus.mem_wvalid), 64'(1));
        chk("t6_pre_arvalid", 64'(bus.mem_arvalid), 64'(1));
        #2;
        aresetn = 1'b0;
        #1;
        chk("t6_rst_wvalid", 64'(bus.mem_wvalid), 64'(0));
        chk("t6_rst_arvalid", 64'(bus.mem_arvalid), 64'(0));
        chk("t6_rst_awvalid", 64'(bus.mem_awvalid), 64'(0));
        chk("t6_rst_wready", 64'(bus.s_wready), 64'(0));
        bus.s_wvalid = '0; bus.s_arvalid = '0;
        tick();
        aresetn = 1'b1;
        bus.mem_awready = 1'b0;
        bus.s_awvalid = 2'b11; bus.s_arvalid = 2'b11;
        tick();
        chk("t6_post_awvalid", 64'(bus.mem_awvalid), 64'(1));
        chk("t6_post_awid", 64'(bus.mem_awid), 64'(0));
        chk("t6_post_arvalid", 64'(bus.mem_arvalid), 64'(1));
        chk("t6_post_arid", 64'(bus.mem_arid), 64'(0));
        bus.s_awvalid = '0; bus.s_arvalid = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
